// File: rtl/si_frame_decoder_if.sv
// Byte-stream input and Simple Interface register port of the frame decoder.
// The decoder connects through the slave modport; the host side uses master.
interface si_frame_decoder_if;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        rx_ack;
  logic [15:0] register_addr;
  logic [15:0] register_data;
  logic        register_rdy;
  logic        register_ack;

  modport master (
    output rx_data, rx_rdy, register_ack,
    input  rx_ack, register_addr, register_data, register_rdy
  );

  modport slave (
    input  rx_data, rx_rdy, register_ack,
    output rx_ack, register_addr, register_data, register_rdy
  );
endinterface

// File: rtl/si_frame_decoder.sv
// Assembles 4-byte write frames (addr_hi, addr_lo, data_hi, data_lo) from a byte
// stream and presents them on the register port; stale partial frames time out.
//
// state   | meaning
// S_B0    | waiting for addr_hi
// S_B1    | waiting for addr_lo
// S_B2    | waiting for data_hi
// S_B3    | waiting for data_lo
// S_ISSUE | frame presented, byte stream back-pressured until register_ack
module si_frame_decoder #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic               clk,
  input  logic               rst,
  si_frame_decoder_if.slave  bus,
  output logic               frame_err,
  output logic               busy
);

  typedef enum logic [2:0] {S_B0, S_B1, S_B2, S_B3, S_ISSUE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic        frame_err_nxt;
  logic        xfer;
  logic        timeout_hit;

  // rx_ack is gated by rst so nothing is accepted while reset is held.
  assign xfer        = bus.rx_rdy && rst && (state != S_ISSUE);
  assign bus.rx_ack  = xfer;
  assign busy        = (state != S_B0);
  // A transfer in the terminal cycle wins over the timeout.
  assign timeout_hit = !xfer && (cnt == TIMEOUT - 16'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_B0;
      cnt       <= 16'd0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    frame_err_nxt = 1'b0;
    case (state)
      S_B0: begin
        cnt_nxt = 16'd0;
        if (xfer) state_nxt = S_B1;
      end
      S_B1, S_B2, S_B3: begin
        if (xfer) begin
          cnt_nxt = 16'd0;
          case (state)
            S_B1:    state_nxt = S_B2;
            S_B2:    state_nxt = S_B3;
            default: state_nxt = S_ISSUE;
          endcase
        end else if (timeout_hit) begin
          cnt_nxt       = 16'd0;
          state_nxt     = S_B0;
          frame_err_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      S_ISSUE: begin
        cnt_nxt = 16'd0;
        if (bus.register_ack) state_nxt = S_B0;
      end
      default: begin
        cnt_nxt   = 16'd0;
        state_nxt = S_B0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.register_addr <= 16'h0000;
      bus.register_data <= 16'h0000;
      bus.register_rdy  <= 1'b0;
    end else begin
      if (xfer) begin
        case (state)
          S_B0:    bus.register_addr[15:8] <= bus.rx_data;
          S_B1:    bus.register_addr[7:0]  <= bus.rx_data;
          S_B2:    bus.register_data[15:8] <= bus.rx_data;
          S_B3:    bus.register_data[7:0]  <= bus.rx_data;
          default: ;
        endcase
      end
      if (xfer && state == S_B3)
        bus.register_rdy <= 1'b1;
      else if (state == S_ISSUE && bus.register_ack)
        bus.register_rdy <= 1'b0;
    end
  end

endmodule

// File: doc/si_frame_decoder.md
# si_frame_decoder

Byte-stream command decoder that sits directly upstream of the configuration register bank. It takes bytes from the host link receiver and assembles them into 4-byte write frames: address high, address low, data high, data low, MSB first. Each completed frame is presented on the Simple Interface register port (`register_addr` / `register_data` / `register_rdy` / `register_ack`). An inter-byte timeout discards partial frames so the stream can resynchronise.

## Interface
Parameters:
- `TIMEOUT`, default 16'd50000: idle cycles allowed between bytes of one frame before the partial frame is discarded. Legal range 2..65535.

Ports:
- `clk`, in, 1: system clock; all logic on rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `rx_data`, in, 8: received byte.
- `rx_rdy`, in, 1: byte valid. The source holds it and `rx_data` stable until the transfer completes.
- `rx_ack`, out, 1: byte accepted. Combinational: `rx_rdy` AND state in S_B0..S_B3. A transfer occurs at the edge where `rx_rdy` = `rx_ack` = 1.
- `register_addr`, out, 16: frame address, registered.
- `register_data`, out, 16: frame data, registered.
- `register_rdy`, out, 1: frame valid, registered. Held until acknowledged.
- `register_ack`, in, 1: register bank acknowledge.
- `frame_err`, out, 1: one-cycle pulse when a partial frame is discarded on timeout.
- `busy`, out, 1: high in S_B1..S_ISSUE, i.e. a frame is partially received or pending.

## Operation
- States:
  - S_B0: waiting for addr_hi.
  - S_B1: addr_lo.
  - S_B2: data_hi.
  - S_B3: data_lo.
  - S_ISSUE: frame presented.
- Byte capture on transfer:
  - S_B0: `register_addr[15:8]`, go to S_B1.
  - S_B1: `register_addr[7:0]`, go to S_B2.
  - S_B2: `register_data[15:8]`, go to S_B3.
  - S_B3: `register_data[7:0]`, go to S_ISSUE and set `register_rdy`.
- `register_addr` and `register_data` only change on capture. They are stable throughout S_ISSUE.
- S_ISSUE: `rx_ack` = 0, so the byte stream is back-pressured. When `register_ack` is sampled 1: clear `register_rdy` and go to S_B0.
- `register_ack` is ignored in every state other than S_ISSUE.
- Timeout counter (16 bits):
  - Cleared on every byte transfer and in S_B0 / S_ISSUE.
  - In S_B1..S_B3, increments each cycle without a transfer.
  - When the count equals `TIMEOUT`: go to S_B0, pulse `frame_err` for one cycle, clear the counter. Captured bytes are left in the registers but are never issued.
  - A transfer in the same cycle the count reaches `TIMEOUT` wins: the byte is accepted and there is no error.
- No timeout in S_ISSUE; the block waits for `register_ack` indefinitely.
- Address and data are passed through unchecked; range checking belongs to the register bank.
- Reset (async assert, any state):
  - State → S_B0, counter → 0.
  - `register_addr`, `register_data` → 16'h0000.
  - `register_rdy`, `frame_err` → 0.
  - `busy` → 0. `rx_ack` is 0 while `rst` is low.

## Timing
- At most one byte per cycle.
- Last-byte transfer at edge N → `register_rdy` high from N (visible in cycle N+1).
- `register_ack` sampled at edge M → `register_rdy` low after M, and the state is S_B0 in the same cycle. `rx_ack` may fire in the cycle after M.
- Minimum frame period is 5 cycles: 4 byte transfers plus 1 issue cycle with a same-cycle ack.
- `frame_err` asserts the cycle after the edge where the count reaches `TIMEOUT`, for exactly one cycle.
- Reset deassertion is synchronised externally; the block is operational on the first edge after `rst` goes high.

## Test plan
- Single frame: bytes 0x00,0x01,0x12,0x34 on consecutive cycles, `register_ack` tied high.
  - Expect `register_rdy` for 1 cycle with `register_addr` = 0x0001, `register_data` = 0x1234.
  - Expect 4 `rx_ack` pulses.
- Slow ack: frame 0x00,0x03,0x04,0x00, then `register_ack` 7 cycles after `register_rdy` rises.
  - Expect `register_rdy` held for 7 cycles with data 0x0400 stable.
  - Expect `rx_ack` = 0 with `rx_rdy` high throughout; the next byte is accepted the cycle after the ack.
- Timeout: `TIMEOUT` = 10; send 0x00,0x02, then idle.
  - Expect one `frame_err` pulse after exactly 10 idle cycles and `busy` → 0.
  - A following 0x00,0x10,0x00,0x01 frame issues addr 0x0010 / data 0x0001.
- Boundary timeout: with `TIMEOUT` = 10, a byte arriving on the 10th idle cycle is accepted with no `frame_err`.
- Back-to-back: three frames streamed with `register_ack` tied high.
  - Expect 3 `register_rdy` pulses, one every 5 cycles, with correct addr/data each time.
- Reset mid-frame: assert `rst` low after 3 bytes.
  - Expect all outputs at reset values immediately and no `register_rdy`.
  - After release, a fresh 4-byte frame decodes correctly.
